// File: rtl/lms_controller.sv
// rtl/lms_controller.sv - LMS filter sequencer: steps data_path through read, y/e/w update and
// weight write-back for NUM_SAMPLES samples per frame, with a per-state wait watchdog.
module lms_controller #(
  parameter int NUM_SAMPLES = 50,
  parameter int TIMEOUT     = 255
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       done_read_Dn,
  input  logic       done_read_Xn,
  input  logic       done_yn,
  input  logic       done_en,
  input  logic       done_wn1,
  input  logic       done_write_wn,
  output logic       memory_Dn_active,
  output logic       memory_Xn_active,
  output logic       memory_bobot_active,
  output logic       y_active,
  output logic       e_active,
  output logic       w_active,
  output logic       sys_reset_active,
  output logic       busy,
  output logic       sample_done,
  output logic       frame_done,
  output logic       error,
  output logic [7:0] sample_count
);

  typedef enum logic [3:0] {
    IDLE, CLEAR, READ, CALC_Y, CALC_E, CALC_W, WRITE_W, NEXT, FINISH, ERR
  } state_t;

  // A wait state is abandoned on the cycle whose counter value is TIMEOUT-1,
  // giving exactly TIMEOUT cycles in the state before ERR.
  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);
  localparam logic [7:0] FRAME_LEN = 8'(NUM_SAMPLES);

  state_t     state;
  state_t     state_next;
  logic       sticky_dn;
  logic       sticky_xn;
  logic [7:0] wait_cnt;
  logic       read_done;
  logic       timed_out;
  logic       waiting;

  always_comb begin
    read_done = (sticky_dn | done_read_Dn) & (sticky_xn | done_read_Xn);
    timed_out = (wait_cnt == LAST_WAIT);
    waiting   = (state == READ) || (state == CALC_Y) || (state == CALC_E) ||
                (state == CALC_W) || (state == WRITE_W);
  end

  // Exit conditions are tested before the watchdog so a late done still wins.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CLEAR;
      CLEAR:   state_next = READ;
      READ:    if (read_done)     state_next = CALC_Y;
               else if (timed_out) state_next = ERR;
      CALC_Y:  if (done_yn)       state_next = CALC_E;
               else if (timed_out) state_next = ERR;
      CALC_E:  if (done_en)       state_next = CALC_W;
               else if (timed_out) state_next = ERR;
      CALC_W:  if (done_wn1)      state_next = WRITE_W;
               else if (timed_out) state_next = ERR;
      WRITE_W: if (done_write_wn) state_next = NEXT;
               else if (timed_out) state_next = ERR;
      NEXT:    state_next = (sample_count == FRAME_LEN) ? FINISH : READ;
      FINISH:  state_next = IDLE;
      ERR:     if (start) state_next = CLEAR;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state               <= IDLE;
      sticky_dn           <= 1'b0;
      sticky_xn           <= 1'b0;
      wait_cnt            <= 8'd0;
      memory_Dn_active    <= 1'b0;
      memory_Xn_active    <= 1'b0;
      memory_bobot_active <= 1'b0;
      y_active            <= 1'b0;
      e_active            <= 1'b0;
      w_active            <= 1'b0;
      sys_reset_active    <= 1'b0;
      busy                <= 1'b0;
      sample_done         <= 1'b0;
      frame_done          <= 1'b0;
      error               <= 1'b0;
      sample_count        <= 8'd0;
    end else begin
      state     <= state_next;
      sticky_dn <= (state == READ) && (state_next == READ) && (sticky_dn | done_read_Dn);
      sticky_xn <= (state == READ) && (state_next == READ) && (sticky_xn | done_read_Xn);

      if (waiting && (state_next == state)) begin
        wait_cnt <= wait_cnt + 8'd1;
      end else begin
        wait_cnt <= 8'd0;
      end

      memory_Dn_active    <= (state_next == READ);
      memory_Xn_active    <= (state_next == READ);
      memory_bobot_active <= (state_next == READ) || (state_next == WRITE_W);
      y_active            <= (state_next == CALC_Y);
      e_active            <= (state_next == CALC_E);
      w_active            <= (state_next == CALC_W);
      sys_reset_active    <= (state_next == CLEAR);
      busy                <= (state_next != IDLE) && (state_next != ERR);
      sample_done         <= (state_next == NEXT);
      frame_done          <= (state_next == FINISH);
      error               <= (state_next == ERR);

      if (state_next == CLEAR) begin
        sample_count <= 8'd0;
      end else if (state_next == NEXT) begin
        sample_count <= sample_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_lms_controller.sv
// tb/tb_lms_controller.sv - scoreboard bench for lms_controller with a reactive done responder
`timescale 1ns/1ps
module tb_lms_controller;

  localparam int NS = 3;
  localparam int TO = 10;

  // Per-frame plan: for sample i, stage s (0 Dn, 1 Xn, 2 y, 3 e, 4 w, 5 write) the done
  // arrives after this many cycles of its enable; >= TO means it never arrives in time.
  typedef logic [NS*6-1:0][7:0] plan_t;

  typedef struct packed {
    logic [1:0]  kind;   // 0 clear, 1 sample_done, 2 frame_done, 3 error entry
    logic [31:0] cyc;
    logic [7:0]  val;    // sample_count seen with the event
  } ev_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic done_read_Dn, done_read_Xn, done_yn, done_en, done_wn1, done_write_wn;
  logic memory_Dn_active, memory_Xn_active, memory_bobot_active;
  logic y_active, e_active, w_active, sys_reset_active;
  logic busy, sample_done, frame_done, error;
  logic [7:0] sample_count;

  int    cyc = 0;
  int    n_cmp = 0;
  int    n_fail = 0;
  ev_t   exp_q[$];
  plan_t plan_q[$];
  plan_t cur;
  logic  noise = 1'b0;

  lms_controller #(.NUM_SAMPLES(NS), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .start(start),
    .done_read_Dn(done_read_Dn), .done_read_Xn(done_read_Xn), .done_yn(done_yn),
    .done_en(done_en), .done_wn1(done_wn1), .done_write_wn(done_write_wn),
    .memory_Dn_active(memory_Dn_active), .memory_Xn_active(memory_Xn_active),
    .memory_bobot_active(memory_bobot_active), .y_active(y_active), .e_active(e_active),
    .w_active(w_active), .sys_reset_active(sys_reset_active), .busy(busy),
    .sample_done(sample_done), .frame_done(frame_done), .error(error),
    .sample_count(sample_count)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [18:0] outs();
    return {memory_Dn_active, memory_Xn_active, memory_bobot_active, y_active, e_active,
            w_active, sys_reset_active, busy, sample_done, frame_done, error, sample_count};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: timeline of observable events for one frame whose CLEAR cycle is t0.
  function automatic void model_frame(input plan_t p, input int t0, output int t_end,
                                      output bit err);
    int t;
    int m;
    exp_q.push_back('{kind: 2'd0, cyc: 32'(t0), val: 8'd0});
    t = t0 + 1;
    err = 1'b0;
    for (int i = 0; i < NS; i++) begin
      for (int st = 0; st < 5; st++) begin
        if (st == 0) m = (p[i*6] > p[i*6+1]) ? int'(p[i*6]) : int'(p[i*6+1]);
        else         m = int'(p[i*6+st+1]);
        if (m >= TO) begin
          exp_q.push_back('{kind: 2'd3, cyc: 32'(t + TO), val: 8'(i)});
          t_end = t + TO;
          err = 1'b1;
          return;
        end
        t += m + 1;
      end
      exp_q.push_back('{kind: 2'd1, cyc: 32'(t), val: 8'(i + 1)});
      t += 1;
    end
    exp_q.push_back('{kind: 2'd2, cyc: 32'(t), val: 8'(NS)});
    t_end = t;
  endfunction

  task automatic take(input int k, input logic [7:0] v);
    ev_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got kind %0d count %0d at cycle %0d, expected no event",
               k, v, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != 2'(k) || e.cyc != 32'(cyc) || e.val != v) begin
        n_fail++;
        $display("FAIL event: got kind %0d cycle %0d count %0d, expected kind %0d cycle %0d count %0d",
                 k, cyc, v, e.kind, e.cyc, e.val);
      end
    end
  endtask

  // Monitor: pops the scoreboard on every observable event and checks enable rules each cycle.
  logic err_prev = 1'b0;
  always @(negedge clock) begin : monitor
    int  n_en;
    bit  ok;
    if (reset) begin
      err_prev = 1'b0;
    end else begin
      n_en = int'(memory_Dn_active) + int'(memory_Xn_active) + int'(memory_bobot_active) +
             int'(y_active) + int'(e_active) + int'(w_active) + int'(sys_reset_active);
      ok = (n_en <= 1) ||
           (n_en == 3 && memory_Dn_active && memory_Xn_active && memory_bobot_active);
      if (error) ok = ok && (n_en == 0) && !busy;
      if (n_en != 0 || sample_done || frame_done) ok = ok && busy;
      check("enable_rules", 32'(ok), 32'd1);
      if (sys_reset_active) take(0, sample_count);
      if (sample_done)      take(1, sample_count);
      if (frame_done)       take(2, sample_count);
      if (error && !err_prev) take(3, sample_count);
      err_prev = error;
    end
  end

  // Responder: raises each done the planned number of cycles after its enable rises;
  // optionally sprays done flags whose stage is not active.
  int         k [6];
  logic [5:0] act_prev = 6'd0;
  always @(negedge clock) begin : responder
    logic [5:0] act;
    logic [5:0] dn;
    act = {memory_bobot_active & ~memory_Dn_active, w_active, e_active, y_active,
           memory_Xn_active, memory_Dn_active};
    if (sys_reset_active && plan_q.size() != 0) cur = plan_q.pop_front();
    for (int s = 0; s < 6; s++) begin
      if (act[s]) begin
        k[s] = act_prev[s] ? k[s] + 1 : 0;
        dn[s] = (int'(sample_count) < NS) && (k[s] == int'(cur[int'(sample_count)*6+s]));
      end else begin
        dn[s] = noise && ($urandom_range(0, 3) == 0);
      end
    end
    act_prev = act;
    done_read_Dn  = dn[0];
    done_read_Xn  = dn[1];
    done_yn       = dn[2];
    done_en       = dn[3];
    done_wn1      = dn[4];
    done_write_wn = dn[5];
  end

  function automatic plan_t const_plan(input int v);
    plan_t p;
    for (int j = 0; j < NS*6; j++) p[j] = 8'(v);
    return p;
  endfunction

  function automatic plan_t rand_plan(input bit allow_to);
    plan_t p;
    for (int j = 0; j < NS*6; j++) begin
      p[j] = 8'($urandom_range(0, 9));
      if (allow_to && $urandom_range(0, 29) == 0) p[j] = 8'(TO + $urandom_range(0, 3));
    end
    return p;
  endfunction

  task automatic drain_and_idle(input bit err);
    int n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(negedge clock);
      n++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain: got %0d events still pending, expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(negedge clock);
    check("end_state", {30'd0, busy, error}, {30'd0, 1'b0, err});
  endtask

  task automatic run_frame(input plan_t p, input bit jitter);
    int c;
    int t_end;
    bit err;
    @(negedge clock);
    c = cyc;
    start = 1'b1;
    plan_q.push_back(p);
    model_frame(p, c + 1, t_end, err);
    while (cyc < t_end) begin
      @(negedge clock);
      start = (jitter && cyc < t_end) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    start = 1'b0;
    drain_and_idle(err);
  endtask

  initial begin : stimulus
    plan_t p;
    plan_t p2;
    int    c;
    int    e_a;
    int    e_b;
    int    n;
    bit    er;

    #2 reset = 1'b1;
    #1 check("reset_outputs", 32'(outs()), 32'd0);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    check("idle_after_reset", 32'(outs()), 32'd0);

    // Every done one cycle after its enable: samples 11 cycles apart.
    run_frame(const_plan(1), 1'b0);

    noise = 1'b1;
    repeat (6) @(negedge clock);
    check("idle_ignores_done", 32'(outs()), {24'd0, 8'(NS)});

    // Xn early, Dn late in the first READ.
    p = const_plan(1);
    p[1] = 8'd1;
    p[0] = 8'd4;
    run_frame(p, 1'b1);

    // Done on the last legal cycle beats the watchdog.
    run_frame(const_plan(TO - 1), 1'b1);

    // done_en never arrives: ERR, then restart from ERR with zero-latency dones.
    p = const_plan(1);
    p[3] = 8'd255;
    run_frame(p, 1'b1);
    run_frame(const_plan(0), 1'b1);

    // Watchdog boundary on the final write of the last sample.
    p = const_plan(2);
    p[(NS-1)*6+5] = 8'(TO);
    run_frame(p, 1'b0);

    for (int f = 0; f < 12; f++) run_frame(rand_plan(1'b1), 1'b1);

    // start held high across two frames: second CLEAR two cycles after FINISH.
    p  = rand_plan(1'b0);
    p2 = rand_plan(1'b0);
    @(negedge clock);
    c = cyc;
    start = 1'b1;
    plan_q.push_back(p);
    plan_q.push_back(p2);
    model_frame(p, c + 1, e_a, er);
    model_frame(p2, e_a + 2, e_b, er);
    while (cyc < e_b - 3) @(negedge clock);
    start = 1'b0;
    drain_and_idle(1'b0);

    // Reset during CALC_W of the third sample abandons the frame.
    @(negedge clock);
    c = cyc;
    start = 1'b1;
    plan_q.push_back(const_plan(2));
    model_frame(const_plan(2), c + 1, e_a, er);
    @(negedge clock);
    start = 1'b0;
    n = 0;
    while (!(w_active && sample_count == 8'd2) && n < 500) begin
      @(negedge clock);
      n++;
    end
    check("reach_calc_w", {31'd0, w_active}, 32'd1);
    #2 reset = 1'b1;
    #1 check("reset_midframe", 32'(outs()), 32'd0);
    exp_q.delete();
    plan_q.delete();
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (20) @(negedge clock);
    check("stay_idle", 32'(outs()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin : watchdog
    #800000;
    $display("FAIL global_timeout: got no finish by cycle %0d, expected finish", cyc);
    $fatal(1);
  end

endmodule
